wbu: RTL and testbench
======================

# wbu

Writeback unit of the npc single-issue core. It accepts one retiring instruction at a time from the execute stage and, for loads, waits for the LSU read data and sign- or zero-extends it. It then drives the single write port of the integer register file (rd, wen, wdata) and emits a retire pulse for difftest. It also exposes the pending destination register so decode can stall on a read-after-write hazard.

## Interface
Parameters:
- TIMEOUT, 255: max cycles spent in WAIT_LOAD before an error retire; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  execute stage offers an instruction
- in_ready  out  1  wbu can accept this cycle
- in_rd  in  5  destination register index
- in_wen  in  1  instruction writes rd
- in_result  in  32  ALU/CSR result (ignored for loads)
- in_is_load  in  1  instruction is a load
- in_funct3  in  3  load width/sign encoding
- in_addr_lo  in  2  load address bits [1:0]
- in_pc  in  32  instruction pc
- lsu_rvalid  in  1  load data valid (single-cycle pulse)
- lsu_rdata  in  32  aligned 32-bit word from memory
- rf_wen  out  1  register file write enable
- rf_rd  out  5  register file write index
- rf_wdata  out  32  register file write data
- busy  out  1  a write to a nonzero rd is pending
- busy_rd  out  5  index of that pending rd
- retire_valid  out  1  one-cycle retire pulse
- retire_pc  out  32  pc of the retiring instruction
- retire_err  out  1  retire caused by illegal funct3 or load timeout

## Operation
- States: IDLE, WAIT_LOAD, WRITE.
- The unit accepts an instruction when in_valid && in_ready. It latches rd, wen, result, is_load, funct3, addr_lo and pc.
  - Load: go to WAIT_LOAD.
  - Non-load: go to WRITE with wdata = result.
- in_ready = (state==IDLE) || (state==WRITE). This allows back-to-back accept in WRITE.
- WAIT_LOAD: lsu_rvalid is sampled only in this state and is ignored in every other state.
  - On lsu_rvalid: wdata = ext(lsu_rdata), go to WRITE.
  - The watchdog counter increments each WAIT_LOAD cycle. When it reaches TIMEOUT: set err, suppress the write, go to WRITE.
- Load extension by funct3:
  - 000 lb: byte at addr_lo, sign-extended.
  - 001 lh: halfword at addr_lo[1], sign-extended.
  - 010 lw: full word; addr_lo ignored.
  - 100 lbu: byte at addr_lo, zero-extended.
  - 101 lhu: halfword at addr_lo[1], zero-extended.
  - Any other value: wdata = 0, err set, write suppressed.
- WRITE, for exactly one cycle:
  - rf_wen = wen && rd!=0 && !err; rf_rd/rf_wdata come from the latch.
  - retire_valid = 1, retire_pc = latched pc, retire_err = err.
  - Next state: the new accept target if an instruction is accepted this cycle, else IDLE.
- rf_wen is never asserted for rd==0.
- busy = (state!=IDLE) && wen && rd!=0; busy_rd = latched rd (0 when not busy).

## Timing
- Reset: state=IDLE. The following outputs are 0: rf_wen, rf_rd, rf_wdata, retire_valid, retire_pc, retire_err, busy, busy_rd. The watchdog counter is cleared.
- Reset mid-operation: a pending instruction is dropped with no write and no retire.
- Non-load: accept at cycle N, rf_wen/retire_valid at N+1.
- Load: accept at N, lsu_rvalid at M>N, rf_wen/retire_valid at M+1.
- lsu_rvalid in the same cycle as the load's accept is ignored; the LSU must respond no earlier than N+1.
- Sustained non-load throughput: 1 per cycle.
- The watchdog counter is 8 bits wide. It is cleared on entering WAIT_LOAD. The timeout retire occurs TIMEOUT+1 cycles after accept.
- All outputs are registered or decoded from registered state. There is no combinational path from the in_* inputs to rf_* or retire_* outputs.

## Structure
- Shared package npc_pkg holds:
  - funct3 load encodings: LB, LH, LW, LBU, LHU.
  - the wbu state enum.
  - the XLEN=32 constant.
- One combinational sub-module, load_ext, with inputs (funct3, addr_lo, rdata) and outputs (data, illegal). It is instantiated once.

## Test plan
- Non-load: accept rd=5, result=0xDEADBEEF, in_wen=1 -> next cycle rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF, retire_valid=1.
- lb: funct3=000, addr_lo=3, lsu_rdata=0x80112233 arriving after 4 cycles -> rf_wdata=0xFFFFFF80. busy=1 with busy_rd=rd throughout the wait.
- lhu: funct3=101, addr_lo=2, lsu_rdata=0xBEEF1234 -> rf_wdata=0x0000BEEF. Same data with lh -> 0xFFFFBEEF.
- rd=0 write, plus back-to-back non-loads on consecutive cycles -> rf_wen stays 0 for rd=0. The other writes land one per cycle with in_ready held high.
- Illegal funct3=011 load -> no rf_wen, retire_err=1. With TIMEOUT=4 and no lsu_rvalid -> retire_err=1 at accept+5.
- rst asserted during WAIT_LOAD -> next cycle IDLE with all outputs 0. A later lsu_rvalid is ignored and produces no write.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared definitions for the npc core: datapath width, load funct3 encodings
// and the writeback unit state encoding.
package npc_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOAD,
        WRITE
    } wbu_state_e;

endpackage

// File: rtl/wbu_load_ext.sv
// Load data extraction: picks the byte/halfword addressed by addr_lo out of an
// aligned word and sign- or zero-extends it; flags funct3 values that are not loads.
module load_ext
    import npc_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            LB:      data = {{(XLEN-8){w_byte[7]}}, w_byte};
            LH:      data = {{(XLEN-16){w_half[15]}}, w_half};
            LW:      data = rdata;
            LBU:     data = {{(XLEN-8){1'b0}}, w_byte};
            LHU:     data = {{(XLEN-16){1'b0}}, w_half};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wbu.sv
// Writeback unit: retires one instruction at a time, waiting on LSU data for
// loads, and drives the register file write port plus the difftest retire pulse.
module wbu
    import npc_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_wen,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_pc,
    input  logic            lsu_rvalid,
    input  logic [XLEN-1:0] lsu_rdata,
    output logic            rf_wen,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            busy,
    output logic [4:0]      busy_rd,
    output logic            retire_valid,
    output logic [XLEN-1:0] retire_pc,
    output logic            retire_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    wbu_state_e      r_state;
    wbu_state_e      w_next_state;
    logic [4:0]      r_rd;
    logic            r_wen;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic [XLEN-1:0] r_pc;
    logic            r_err;
    logic [7:0]      r_cnt;

    logic            w_accept;
    logic            w_timeout;
    logic            w_in_write;
    logic [XLEN-1:0] w_ext_data;
    logic            w_ext_illegal;

    load_ext u_load_ext (
        .funct3  (r_funct3),
        .addr_lo (r_addr_lo),
        .rdata   (lsu_rdata),
        .data    (w_ext_data),
        .illegal (w_ext_illegal)
    );

    assign in_ready  = (r_state == IDLE) || (r_state == WRITE);
    assign w_accept  = in_valid && in_ready;
    // The count that would be reached this cycle hitting TIMEOUT ends the wait.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt + 8'd1 == TIMEOUT_CNT);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = in_is_load ? WAIT_LOAD : WRITE;
            end
            WAIT_LOAD: begin
                if (lsu_rvalid || w_timeout) w_next_state = WRITE;
            end
            WRITE: begin
                if (w_accept) w_next_state = in_is_load ? WAIT_LOAD : WRITE;
                else          w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd      <= '0;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
            r_funct3  <= '0;
            r_addr_lo <= '0;
            r_pc      <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_rd      <= in_rd;
            r_wen     <= in_wen;
            r_wdata   <= in_is_load ? '0 : in_result;
            r_funct3  <= in_funct3;
            r_addr_lo <= in_addr_lo;
            r_pc      <= in_pc;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else if (r_state == WAIT_LOAD) begin
            if (lsu_rvalid) begin
                r_wdata <= w_ext_data;
                r_err   <= w_ext_illegal;
            end else begin
                r_cnt <= r_cnt + 8'd1;
                if (w_timeout) r_err <= 1'b1;
            end
        end
    end

    // Outputs are decoded from registered state only; nothing in_* reaches them combinationally.
    assign w_in_write   = (r_state == WRITE);
    assign rf_wen       = w_in_write && r_wen && (r_rd != 5'd0) && !r_err;
    assign rf_rd        = w_in_write ? r_rd : '0;
    assign rf_wdata     = w_in_write ? r_wdata : '0;
    assign retire_valid = w_in_write;
    assign retire_pc    = w_in_write ? r_pc : '0;
    assign retire_err   = w_in_write && r_err;
    assign busy         = (r_state != IDLE) && r_wen && (r_rd != 5'd0);
    assign busy_rd      = busy ? r_rd : '0;

endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: a table of single-instruction vectors plus hand-written
// sequences for back-to-back retire, early LSU data, reset mid-load and watchdog.
module tb_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_pc;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;

    logic        in_ready, rf_wen, busy, retire_valid, retire_err;
    logic [4:0]  rf_rd, busy_rd;
    logic [31:0] rf_wdata, retire_pc;

    logic        t_in_ready, t_rf_wen, t_busy, t_retire_valid, t_retire_err;
    logic [4:0]  t_rf_rd, t_busy_rd;
    logic [31:0] t_rf_wdata, t_retire_pc;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    wbu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_wen(in_wen), .in_result(in_result), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_pc(in_pc),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .busy(busy), .busy_rd(busy_rd),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_err(retire_err)
    );

    wbu #(.TIMEOUT(4)) dut_wd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .in_rd(in_rd), .in_wen(in_wen), .in_result(in_result), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_pc(in_pc),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .rf_wen(t_rf_wen), .rf_rd(t_rf_rd), .rf_wdata(t_rf_wdata),
        .busy(t_busy), .busy_rd(t_busy_rd),
        .retire_valid(t_retire_valid), .retire_pc(t_retire_pc), .retire_err(t_retire_err)
    );

    typedef struct {
        logic        is_load;
        logic [2:0]  f3;
        logic [1:0]  addr;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] result;
        logic [31:0] rdata;
        int          delay;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic ld, input logic [2:0] f3, input logic [1:0] a,
                         input logic [4:0] rd, input logic wen, input logic [31:0] res,
                         input logic [31:0] pc);
        in_valid   = 1'b1;
        in_is_load = ld;
        in_funct3  = f3;
        in_addr_lo = a;
        in_rd      = rd;
        in_wen     = wen;
        in_result  = res;
        in_pc      = pc;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_rf_wen"}, rf_wen, 0);
        check({name, "_retire_valid"}, retire_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        vecs[0]  = '{1'b0, 3'b000, 2'd0,  5'd5, 1'b1, 32'hDEADBEEF, 32'h0,        0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 3'b000, 2'd3,  5'd8, 1'b1, 32'h0,        32'h80112233, 4, 1'b1, 32'hFFFFFF80, 1'b0};
        vecs[2]  = '{1'b1, 3'b101, 2'd2,  5'd9, 1'b1, 32'h0,        32'hBEEF1234, 2, 1'b1, 32'h0000BEEF, 1'b0};
        vecs[3]  = '{1'b1, 3'b001, 2'd2, 5'd10, 1'b1, 32'h0,        32'hBEEF1234, 1, 1'b1, 32'hFFFFBEEF, 1'b0};
        vecs[4]  = '{1'b1, 3'b010, 2'd1, 5'd11, 1'b1, 32'h0,        32'h12345678, 3, 1'b1, 32'h12345678, 1'b0};
        vecs[5]  = '{1'b1, 3'b100, 2'd1, 5'd12, 1'b1, 32'h0,        32'h80112233, 1, 1'b1, 32'h00000022, 1'b0};
        vecs[6]  = '{1'b1, 3'b000, 2'd0, 5'd13, 1'b1, 32'h0,        32'h000000F0, 2, 1'b1, 32'hFFFFFFF0, 1'b0};
        vecs[7]  = '{1'b1, 3'b001, 2'd0, 5'd14, 1'b1, 32'h0,        32'h00008001, 1, 1'b1, 32'hFFFF8001, 1'b0};
        vecs[8]  = '{1'b1, 3'b011, 2'd0, 5'd15, 1'b1, 32'h0,        32'hCAFEF00D, 2, 1'b0, 32'h00000000, 1'b1};
        vecs[9]  = '{1'b1, 3'b111, 2'd1, 5'd16, 1'b1, 32'h0,        32'hCAFEF00D, 1, 1'b0, 32'h00000000, 1'b1};
        vecs[10] = '{1'b0, 3'b000, 2'd0,  5'd7, 1'b0, 32'h55AA55AA, 32'h0,        0, 1'b0, 32'h55AA55AA, 1'b0};
        vecs[11] = '{1'b1, 3'b010, 2'd0,  5'd0, 1'b1, 32'h0,        32'h13579BDF, 2, 1'b0, 32'h13579BDF, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_result = '0; in_is_load = 1'b0;
        in_funct3 = '0; in_addr_lo = '0; in_pc = '0; lsu_rvalid = 1'b0; lsu_rdata = '0;
        tick;
        tick;
        check("reset_outputs", {rf_wen, rf_rd, rf_wdata, busy, busy_rd, retire_valid, retire_pc, retire_err}, 0);
        check("reset_wdata", rf_wdata, 0);
        check("reset_retire_pc", retire_pc, 0);
        check("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 12; i++) begin
            logic [31:0] pc;
            logic        exp_busy;
            pc = 32'h8000_0000 + 32'(i * 4);
            exp_busy = vecs[i].wen && (vecs[i].rd != 5'd0);
            offer(vecs[i].is_load, vecs[i].f3, vecs[i].addr, vecs[i].rd, vecs[i].wen, vecs[i].result, pc);
            check($sformatf("v%0d_in_ready", i), in_ready, 1);
            tick;
            in_valid  = 1'b0;
            in_result = 32'h0BAD0BAD;
            if (vecs[i].is_load) begin
                for (int d = 0; d < vecs[i].delay; d++) begin
                    check($sformatf("v%0d_busy_wait%0d", i, d), busy, 32'(exp_busy));
                    check($sformatf("v%0d_busy_rd_wait%0d", i, d), busy_rd, exp_busy ? vecs[i].rd : 5'd0);
                    check($sformatf("v%0d_no_retire_wait%0d", i, d), retire_valid, 0);
                    if (d == vecs[i].delay - 1) begin
                        lsu_rvalid = 1'b1;
                        lsu_rdata  = vecs[i].rdata;
                    end
                    tick;
                end
                lsu_rvalid = 1'b0;
                lsu_rdata  = 32'hFFFF0000;
            end
            check($sformatf("v%0d_rf_wen", i), rf_wen, 32'(vecs[i].exp_wen));
            check($sformatf("v%0d_rf_rd", i), rf_rd, 32'(vecs[i].rd));
            check($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d_retire_valid", i), retire_valid, 1);
            check($sformatf("v%0d_retire_pc", i), retire_pc, pc);
            check($sformatf("v%0d_retire_err", i), retire_err, 32'(vecs[i].exp_err));
            tick;
            check_quiet($sformatf("v%0d_after", i));
        end

        // Back-to-back non-loads, one write per cycle, rd=0 write suppressed.
        begin
            logic [4:0]  rds[4];
            logic [31:0] res[4];
            rds = '{5'd3, 5'd0, 5'd4, 5'd6};
            res = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
            for (int i = 0; i < 4; i++) begin
                offer(1'b0, 3'b000, 2'd0, rds[i], 1'b1, res[i], 32'h9000_0000 + 32'(i * 4));
                check($sformatf("b2b%0d_in_ready", i), in_ready, 1);
                tick;
                check($sformatf("b2b%0d_rf_wen", i), rf_wen, (rds[i] != 5'd0) ? 1 : 0);
                check($sformatf("b2b%0d_rf_rd", i), rf_rd, 32'(rds[i]));
                check($sformatf("b2b%0d_rf_wdata", i), rf_wdata, res[i]);
                check($sformatf("b2b%0d_retire_valid", i), retire_valid, 1);
                check($sformatf("b2b%0d_retire_pc", i), retire_pc, 32'h9000_0000 + 32'(i * 4));
            end
            in_valid = 1'b0;
            tick;
            check_quiet("b2b_drain");
        end

        // lsu_rvalid in the accept cycle must be ignored.
        offer(1'b1, 3'b010, 2'd0, 5'd9, 1'b1, 32'h0, 32'hA000_0000);
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'hAAAA5555;
        tick;
        in_valid   = 1'b0;
        lsu_rvalid = 1'b0;
        check("early_no_retire", retire_valid, 0);
        check("early_busy", busy, 1);
        check("early_in_ready", in_ready, 0);
        tick;
        check("early_still_waiting", retire_valid, 0);
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'h12345678;
        tick;
        lsu_rvalid = 1'b0;
        check("early_rf_wen", rf_wen, 1);
        check("early_rf_wdata", rf_wdata, 32'h12345678);
        tick;

        // Reset while waiting for load data drops the instruction.
        offer(1'b1, 3'b010, 2'd0, 5'd13, 1'b1, 32'h0, 32'hB000_0000);
        tick;
        in_valid = 1'b0;
        tick;
        check("rstwait_busy", busy, 1);
        check("rstwait_busy_rd", busy_rd, 13);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rstwait_outputs", {rf_wen, rf_rd, busy, busy_rd, retire_valid, retire_err}, 0);
        check("rstwait_wdata_pc", rf_wdata | retire_pc, 0);
        check("rstwait_in_ready", in_ready, 1);
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'hFFFFFFFF;
        tick;
        lsu_rvalid = 1'b0;
        check_quiet("rstwait_late_rvalid");
        tick;
        check_quiet("rstwait_late_rvalid2");

        // Watchdog on the TIMEOUT=4 instance: error retire at accept+5.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        offer(1'b1, 3'b010, 2'd0, 5'd12, 1'b1, 32'h0, 32'hC000_0000);
        tick;
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("wd_wait%0d_no_retire", k), t_retire_valid, 0);
            check($sformatf("wd_wait%0d_busy", k), t_busy, 1);
            tick;
        end
        check("wd_retire_valid", t_retire_valid, 1);
        check("wd_retire_err", t_retire_err, 1);
        check("wd_rf_wen", t_rf_wen, 0);
        check("wd_retire_pc", t_retire_pc, 32'hC000_0000);
        check("wd_main_still_waiting", retire_valid, 0);
        tick;
        check("wd_after", t_retire_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
